// File: rtl/fm_pkg.sv
// Shared FM synthesis definitions: word widths, the request word and the
// elaboration-time generator for the 256-entry exponent table.
package fm_pkg;

  localparam int FM_ATT_W  = 13;
  localparam int FM_LIN_W  = 13;
  localparam int FM_MANT_W = 8;
  localparam int FM_EXP_W  = 5;
  localparam int FM_ROM_W  = 10;

  // 1.0 and 2^(1/256) in unsigned Q40 fixed point.
  localparam logic [41:0] FM_EXP_ONE  = 42'd1099511627776;
  localparam logic [41:0] FM_EXP_STEP = 42'd1102492706220;

  // Packed request word as presented by one requester.
  typedef struct packed {
    logic                sign;
    logic [FM_ATT_W-1:0] att;
  } fm_req_t;

  // Table entry for mantissa index idx: round((2^((255-idx)/256) - 1) * 1024).
  // 2^(k/256) is built by multiplying together the powers 2^(2^b/256)
  // selected by the bits of k; each power is the square of the previous one.
  function automatic logic [FM_ROM_W-1:0] fm_exp_rom_value(input logic [FM_MANT_W-1:0] idx);
    logic [7:0]  k;
    logic [41:0] p;
    logic [41:0] c;
    logic [83:0] prod;
    k = 8'd255 - idx;
    p = FM_EXP_ONE;
    c = FM_EXP_STEP;
    for (int b = 0; b < 8; b++) begin
      if (k[0]) begin
        prod = 84'(p) * 84'(c);
        p    = 42'((prod + (84'd1 << 39)) >> 40);
      end else begin
        p = p;
      end
      prod = 84'(c) * 84'(c);
      c    = 42'((prod + (84'd1 << 39)) >> 40);
      k    = k >> 1;
    end
    return FM_ROM_W'((p - FM_EXP_ONE + (42'd1 << 29)) >> 30);
  endfunction

endpackage

// File: rtl/fm_exp_rom.sv
// 256 x 10 exponent ROM, read combinationally. Entry i holds the fractional
// part of 2^((255-i)/256) scaled by 1024, so index 0 is the largest value.
module fm_exp_rom
  import fm_pkg::*;
(
  input  logic [FM_MANT_W-1:0] idx,
  output logic [FM_ROM_W-1:0]  dout
);

  logic [FM_ROM_W-1:0] w_table [0:255];

  for (genvar g = 0; g < 256; g++) begin : g_rom
    localparam logic [FM_ROM_W-1:0] LP_VAL = fm_exp_rom_value(8'(g));
    assign w_table[g] = LP_VAL;
  end

  // Unregistered table read.
  always_comb begin
    dout = w_table[idx];
  end

endmodule

// File: rtl/fm_exp_arbiter.sv
// Shared log-to-linear converter. Round-robin picks one requester per clock,
// stage 1 registers the accepted attenuation, stage 2 does ROM lookup,
// exponent shift and sign and registers the result with a one-hot strobe.
module fm_exp_arbiter
  import fm_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*FM_ATT_W-1:0]  req_att,
  input  logic [NUM_REQ-1:0]           req_sign,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [FM_LIN_W-1:0]          rsp_data
);

  // Arbitration state and stage-1 pipeline registers.
  logic [ID_W-1:0]      r_rr_ptr;
  logic                 r_s1_valid;
  logic [ID_W-1:0]      r_s1_id;
  logic [FM_MANT_W-1:0] r_s1_mant;
  logic [FM_EXP_W-1:0]  r_s1_exp;
  logic                 r_s1_sign;

  // Registered response.
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [FM_LIN_W-1:0]  r_rsp_data;

  // Combinational datapath.
  logic                 w_gnt_found;
  logic [ID_W-1:0]      w_gnt_id;
  logic [NUM_REQ-1:0]   w_gnt_onehot;
  logic                 w_xfer;
  fm_req_t              w_req_words [NUM_REQ];
  fm_req_t              w_sel_req;
  logic [FM_ROM_W-1:0]  w_rom_value;
  logic [11:0]          w_mag_full;
  logic [11:0]          w_mag12;
  logic [FM_LIN_W-1:0]  w_lin_pos;
  logic [FM_LIN_W-1:0]  w_lin;
  logic [NUM_REQ-1:0]   w_rsp_onehot;

  // Scan from the slot after the last grant, wrapping; no grant while in reset.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_gnt_found && rst_n && req_valid[ID_W'((int'(r_rr_ptr) + k) % NUM_REQ)]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end else begin
        w_gnt_id    = w_gnt_id;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_gnt_onehot[g]  = w_gnt_found && (w_gnt_id == ID_W'(g));
    assign w_rsp_onehot[g]  = r_s1_valid && (r_s1_id == ID_W'(g));
    assign w_req_words[g]   = '{sign: req_sign[g], att: req_att[g*FM_ATT_W +: FM_ATT_W]};
  end

  // Request word of the granted slot and the handshake strobe.
  always_comb begin
    w_sel_req = w_req_words[w_gnt_id];
    w_xfer    = |(req_valid & w_gnt_onehot);
  end

  assign req_ready = w_gnt_onehot;

  // Pointer follows accepted grants only; stage 1 captures the accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_mant  <= '0;
      r_s1_exp   <= '0;
      r_s1_sign  <= 1'b0;
    end else if (w_xfer) begin
      r_rr_ptr   <= w_gnt_id;
      r_s1_valid <= 1'b1;
      r_s1_id    <= w_gnt_id;
      r_s1_mant  <= w_sel_req.att[FM_MANT_W-1:0];
      r_s1_exp   <= w_sel_req.att[FM_ATT_W-1:FM_MANT_W];
      r_s1_sign  <= w_sel_req.sign;
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  fm_exp_rom u_exp_rom (
    .idx  (r_s1_mant),
    .dout (w_rom_value)
  );

  // Rebuild the mantissa with its hidden one, shift by the exponent, apply sign.
  always_comb begin
    w_mag_full = {1'b1, w_rom_value, 1'b0};
    if (r_s1_exp >= 5'd12) begin
      w_mag12 = 12'd0;
    end else begin
      w_mag12 = w_mag_full >> r_s1_exp;
    end
    w_lin_pos = {1'b0, w_mag12};
    if (r_s1_sign) begin
      w_lin = 13'd0 - w_lin_pos;
    end else begin
      w_lin = w_lin_pos;
    end
  end

  // Response register; data only moves when a conversion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_rsp_onehot;
      if (r_s1_valid) begin
        r_rsp_data <= w_lin;
      end else begin
        r_rsp_data <= r_rsp_data;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_fm_exp_arbiter.sv
// Bench for fm_exp_arbiter: directed conversions from known values plus
// randomized traffic checked against a queue-based reference model that
// computes the exponent curve with real arithmetic.
module tb_fm_exp_arbiter;

  localparam int N  = 4;
  localparam int AW = 13;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_att;
  logic [N-1:0]    req_sign;
  logic [N-1:0]    rsp_valid;
  logic [12:0]     rsp_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_gnt = N - 1;

  typedef struct {
    int due;
    int id;
    int data;
  } rsp_t;
  rsp_t sbq[$];

  fm_exp_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_att   (req_att),
    .req_sign  (req_sign),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  always #5 clk = ~clk;

  // Count rising edges so expected responses can be scheduled by cycle.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Exponent curve straight from its definition.
  function automatic int rom_ref(input int m);
    real v;
    v = ($pow(2.0, (255.0 - real'(m)) / 256.0) - 1.0) * 1024.0;
    return $rtoi($floor(v + 0.5));
  endfunction

  // Linear value: (2048 + 2*rom) / 2^exp, zero for large exponents, then sign.
  function automatic int conv_ref(input int att, input int sgn);
    int e, m, mag;
    e = att / 256;
    m = att % 256;
    if (e >= 12) mag = 0;
    else mag = (2048 + 2 * rom_ref(m)) / (1 << e);
    if (sgn != 0) return (8192 - mag) % 8192;
    return mag;
  endfunction

  // Rotating priority: first valid requester after the last one granted.
  function automatic int pick_ref(input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last_gnt + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic int att_of(input int i);
    return int'(req_att[i*AW +: AW]);
  endfunction

  task automatic set_att(input int i, input int v);
    req_att[i*AW +: AW] = AW'(v);
  endtask

  task automatic rsp_expect(output logic [N-1:0] ev, output logic [12:0] ed);
    ev = '0;
    ed = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      ev = oh(sbq[0].id);
      ed = 13'(sbq[0].data);
    end
  endtask

  task automatic model_commit(input int g);
    rsp_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) void'(sbq.pop_front());
    if (g >= 0) begin
      e.due  = cyc + 2;
      e.id   = g;
      e.data = conv_ref(att_of(g), int'(req_sign[g]));
      sbq.push_back(e);
      last_gnt = g;
    end
  endtask

  task automatic new_word(input int i);
    if ($urandom_range(0, 3) == 0) set_att(i, $urandom_range(0, 8191));
    else set_att(i, $urandom_range(0, 3071));
    req_sign[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    @(negedge clk);
    total++;
    if (req_ready !== '0) begin
      bad++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000);
    end
    total++;
    if (rsp_valid !== '0 || rsp_data !== '0) begin
      bad++; $display("FAIL reset_rsp got=%b/%h exp=0000/0000", rsp_valid, rsp_data);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rst_n     = 1'b1;
    last_gnt  = N - 1;
    sbq.delete();
  endtask

  task automatic test_single(input int id, input int att, input logic sgn,
                             input logic [12:0] expd, input string name);
    req_valid = oh(id);
    set_att(id, att);
    req_sign[id] = sgn;
    @(negedge clk);
    total++;
    if (req_ready !== oh(id)) begin
      bad++; $display("FAIL %s_grant got=%b exp=%b", name, req_ready, oh(id));
    end
    last_gnt = id;
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    total++;
    if (rsp_valid !== '0) begin
      bad++; $display("FAIL %s_early got=%b exp=0000", name, rsp_valid);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== oh(id) || rsp_data !== expd) begin
      bad++; $display("FAIL %s_rsp got=%b/%h exp=%b/%h", name, rsp_valid, rsp_data, oh(id), expd);
    end
    @(negedge clk);
    total++;
    if (rsp_valid !== '0) begin
      bad++; $display("FAIL %s_strobe got=%b exp=0000", name, rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int g;
    logic [N-1:0] ev;
    logic [12:0]  ed;
    for (int i = 0; i < N; i++) begin
      set_att(i, $urandom_range(0, 2047) + i * 2048);
      req_sign[i] = 1'($urandom_range(0, 1));
    end
    req_valid = '1;
    for (int c = 0; c < 4 * N + 2; c++) begin
      if (c == 4 * N) req_valid = '0;
      @(negedge clk);
      g = pick_ref(req_valid);
      total++;
      if (req_ready !== oh(g)) begin
        bad++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, req_ready, oh(g));
      end
      rsp_expect(ev, ed);
      total++;
      if (rsp_valid !== ev || (ev != '0 && rsp_data !== ed)) begin
        bad++; $display("FAIL rr_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, rsp_valid, rsp_data, ev, ed);
      end
      model_commit(g);
      @(posedge clk); #1;
      if (g >= 0) begin
        set_att(g, $urandom_range(0, 2047) + g * 2048);
        req_sign[g] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic test_streak();
    int g;
    logic [N-1:0] ev;
    logic [12:0]  ed;
    new_word(3);
    req_valid = 4'b1000;
    for (int c = 0; c < 11; c++) begin
      if (c == 5) req_valid = '1;
      if (c == 9) req_valid = '0;
      @(negedge clk);
      g = pick_ref(req_valid);
      if (c == 5) begin
        total++;
        if (req_ready !== 4'b0001) begin
          bad++; $display("FAIL streak_wrap got=%b exp=%b", req_ready, 4'b0001);
        end
      end
      total++;
      if (req_ready !== oh(g)) begin
        bad++; $display("FAIL streak_grant cyc=%0d got=%b exp=%b", cyc, req_ready, oh(g));
      end
      rsp_expect(ev, ed);
      total++;
      if (rsp_valid !== ev || (ev != '0 && rsp_data !== ed)) begin
        bad++; $display("FAIL streak_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, rsp_valid, rsp_data, ev, ed);
      end
      model_commit(g);
      @(posedge clk); #1;
      if (g >= 0) new_word(g);
    end
  endtask

  task automatic test_random();
    int g;
    logic [N-1:0] ev;
    logic [12:0]  ed;
    g = -1;
    for (int c = 0; c < 302; c++) begin
      for (int i = 0; i < N; i++) begin
        if (c >= 300) begin
          if (!req_valid[i] || i == g) req_valid[i] = 1'b0;
        end else if (!req_valid[i] || i == g) begin
          req_valid[i] = ($urandom_range(0, 99) < 40);
          if (req_valid[i]) new_word(i);
        end
      end
      @(negedge clk);
      g = pick_ref(req_valid);
      total++;
      if (req_ready !== oh(g)) begin
        bad++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_ready, oh(g));
      end
      rsp_expect(ev, ed);
      total++;
      if (rsp_valid !== ev || (ev != '0 && rsp_data !== ed)) begin
        bad++; $display("FAIL rand_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, rsp_valid, rsp_data, ev, ed);
      end
      model_commit(g);
      @(posedge clk); #1;
    end
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rsp_expect(ev, ed);
      total++;
      if (rsp_valid !== ev || (ev != '0 && rsp_data !== ed)) begin
        bad++; $display("FAIL rand_drain cyc=%0d got=%b/%h exp=%b/%h", cyc, rsp_valid, rsp_data, ev, ed);
      end
      model_commit(-1);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    int g;
    logic [N-1:0] ev;
    logic [12:0]  ed;
    for (int i = 0; i < N; i++) new_word(i);
    set_att(0, 12'h100);
    set_att(1, 12'h020);
    req_valid = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      g = pick_ref(req_valid);
      total++;
      if (req_ready !== oh(g)) begin
        bad++; $display("FAIL mid_grant cyc=%0d got=%b exp=%b", cyc, req_ready, oh(g));
      end
      model_commit(g);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== '0 || rsp_data !== '0 || req_ready !== '0) begin
      bad++; $display("FAIL mid_reset got=%b/%h/%b exp=0000/0000/0000", rsp_valid, rsp_data, req_ready);
    end
    sbq.delete();
    last_gnt = N - 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) req_valid = '0;
      @(negedge clk);
      g = pick_ref(req_valid);
      if (c == 0) begin
        total++;
        if (req_ready !== 4'b0001) begin
          bad++; $display("FAIL mid_first got=%b exp=%b", req_ready, 4'b0001);
        end
      end
      total++;
      if (req_ready !== oh(g)) begin
        bad++; $display("FAIL mid_regrant cyc=%0d got=%b exp=%b", cyc, req_ready, oh(g));
      end
      rsp_expect(ev, ed);
      total++;
      if (rsp_valid !== ev || (ev != '0 && rsp_data !== ed)) begin
        bad++; $display("FAIL mid_rsp cyc=%0d got=%b/%h exp=%b/%h", cyc, rsp_valid, rsp_data, ev, ed);
      end
      model_commit(g);
      @(posedge clk); #1;
      if (g >= 0) new_word(g);
    end
  endtask

  initial begin
    req_valid = '0;
    req_att   = '0;
    req_sign  = '0;
    test_reset();
    test_single(0, 'h000,  1'b0, 13'h0FF4, "att000_pos");
    test_single(2, 'h1FF,  1'b0, 13'h0400, "att1ff_pos");
    test_single(2, 'h1FF,  1'b1, 13'h1C00, "att1ff_neg");
    test_single(1, 'hC00,  1'b0, 13'h0000, "exp12_pos");
    test_single(1, 'hC00,  1'b1, 13'h0000, "exp12_neg");
    test_single(1, 'h1FFF, 1'b0, 13'h0000, "att1fff");
    test_round_robin();
    test_streak();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
